// File: rtl/mbus_master_tx_sched_pkg.sv
// Shared widths, FSM encoding and index-width helpers for the MBus TX scheduler.
// Optional retry support is enabled with `define MBUS_TX_RETRY_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mbus_master_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_REQ,
        ST_ACKHI,
        ST_ACKLO,
        ST_RESP,
        ST_RESPCLR
    } tx_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A zero-width index is illegal, so single-entry sizes still get one bit.
    function automatic int idx_w(input int v);
        return (v > 1) ? clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mbus_master_tx_sched_if.sv
// Node-side TX bus of the MBus master: word handshake plus response handshake.
// master = scheduler side, slave = node side.
interface mbus_master_tx_sched_if #(
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int DATA_W = `DATA_WIDTH
);
    logic [ADDR_W-1:0] TX_ADDR;
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_PEND;
    logic              TX_REQ;
    logic              TX_ACK;
    logic              PRIORITY;
    logic              TX_SUCC;
    logic              TX_FAIL;
    logic              TX_RESP_ACK;

    modport master (
        output TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK,
        input  TX_ACK, TX_SUCC, TX_FAIL
    );

    modport slave (
        input  TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK,
        output TX_ACK, TX_SUCC, TX_FAIL
    );
endinterface

// File: rtl/mbus_tx_chan_buf.sv
// One client channel's message buffer: word storage, write/last index,
// addr/prio/trunc capture and ready/full flags.
module mbus_tx_chan_buf
    import mbus_master_tx_sched_pkg::*;
#(
    parameter  int ADDR_W = 8,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int IW     = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic              wr_last,
    input  logic              wr_prio,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IW-1:0]     rd_idx,
    input  logic              free,
    output logic              ready,
    output logic              full,
    output logic              prio,
    output logic              trunc,
    output logic [ADDR_W-1:0] addr,
    output logic [IW-1:0]     last_idx,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic [IW-1:0]     last_idx_q, last_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              prio_q, prio_d;
    logic              trunc_q, trunc_d;
    logic              full_q, full_d;
    logic              acc;
    logic              at_end;

    always_comb begin
        mem_d      = mem_q;
        wr_idx_d   = wr_idx_q;
        last_idx_d = last_idx_q;
        addr_d     = addr_q;
        prio_d     = prio_q;
        trunc_d    = trunc_q;
        full_d     = full_q;
        acc        = wr_valid && !full_q;
        at_end     = (wr_idx_q == IW'(DEPTH - 1));
        if (acc) begin
            mem_d[wr_idx_q] = wr_data;
            if (wr_idx_q == '0) begin
                addr_d = wr_addr;
                prio_d = wr_prio;
            end
            // Running out of slots without LAST force-closes the message.
            if (wr_last || at_end) begin
                full_d     = 1'b1;
                last_idx_d = wr_idx_q;
                trunc_d    = !wr_last;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (free) begin
            full_d   = 1'b0;
            wr_idx_d = '0;
            trunc_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_idx_q   <= '0;
            last_idx_q <= '0;
            addr_q     <= '0;
            prio_q     <= 1'b0;
            trunc_q    <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_idx_q   <= wr_idx_d;
            last_idx_q <= last_idx_d;
            addr_q     <= addr_d;
            prio_q     <= prio_d;
            trunc_q    <= trunc_d;
            full_q     <= full_d;
        end
    end

    assign ready    = !full_q;
    assign full     = full_q;
    assign prio     = prio_q;
    assign trunc    = trunc_q;
    assign addr     = addr_q;
    assign last_idx = last_idx_q;
    assign rd_data  = mem_q[rd_idx];
endmodule

// File: rtl/mbus_master_tx_sched.sv
// Multi-channel MBus TX scheduler: prio/round-robin arbiter, word and response
// handshake FSM, node-input synchronisers. Retry on failure: MBUS_TX_RETRY_EN.
module mbus_master_tx_sched
    import mbus_master_tx_sched_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = `ADDR_WIDTH,
    parameter int DATA_W    = `DATA_WIDTH,
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                     CLKIN,
    input  logic                     RESETn,
    input  logic [NUM_CH-1:0]        CH_VALID,
    output logic [NUM_CH-1:0]        CH_READY,
    input  logic [NUM_CH-1:0]        CH_LAST,
    input  logic [NUM_CH-1:0]        CH_PRIO,
    input  logic [NUM_CH*ADDR_W-1:0] CH_ADDR,
    input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
    output logic [NUM_CH-1:0]        CH_DONE,
    output logic [NUM_CH-1:0]        CH_ERR,
    output logic [NUM_CH-1:0]        CH_TRUNC,
    mbus_master_tx_sched_if.master   tx
);
    localparam int IW = idx_w(DEPTH);
    localparam int CW = idx_w(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > 8 || DEPTH < 1 || MAX_RETRY < 0) begin : g_bad_cfg
        $error("mbus_master_tx_sched: unsupported parameter set");
    end

    logic [NUM_CH-1:0] b_full, b_prio, b_trunc, free_ch;
    logic [ADDR_W-1:0] b_addr [NUM_CH];
    logic [IW-1:0]     b_last [NUM_CH];
    logic [DATA_W-1:0] b_data [NUM_CH];

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     ch_q, ch_d, rr_q, rr_d;
    logic [IW-1:0]     word_q, word_d;
    logic              fail_q, fail_d;
    logic              req_q, req_d;
    logic              rack_q, rack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pend_q, pend_d;
    logic              prio_q, prio_d;
    logic [NUM_CH-1:0] done_q, done_d, err_q, err_d, trunc_q, trunc_d;
    logic [2:0]        sync1_q, sync2_q;
    logic              ack_s, succ_s, fail_s;
    logic              close_msg;
    logic [CW-1:0]     win, win_hi, win_lo;
    logic              hit_hi, hit_lo;

`ifdef MBUS_TX_RETRY_EN
    localparam int RW = idx_w(MAX_RETRY + 1);
    logic [RW-1:0] retry_q, retry_d;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mbus_tx_chan_buf #(
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W),
            .DEPTH (DEPTH)
        ) u_buf (
            .clk     (CLKIN),
            .rst_n   (RESETn),
            .wr_valid(CH_VALID[i]),
            .wr_last (CH_LAST[i]),
            .wr_prio (CH_PRIO[i]),
            .wr_addr (CH_ADDR[i*ADDR_W +: ADDR_W]),
            .wr_data (CH_DATA[i*DATA_W +: DATA_W]),
            .rd_idx  (word_q),
            .free    (free_ch[i]),
            .ready   (CH_READY[i]),
            .full    (b_full[i]),
            .prio    (b_prio[i]),
            .trunc   (b_trunc[i]),
            .addr    (b_addr[i]),
            .last_idx(b_last[i]),
            .rd_data (b_data[i])
        );
    end

    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {tx.TX_FAIL, tx.TX_SUCC, tx.TX_ACK};
            sync2_q <= sync1_q;
        end
    end

    assign ack_s  = sync2_q[0];
    assign succ_s = sync2_q[1];
    assign fail_s = sync2_q[2];

    // First full channel at or after the RR pointer, per priority class.
    always_comb begin
        logic [CW:0]   s;
        logic [CW-1:0] j;
        s      = '0;
        j      = '0;
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            s = {1'b0, rr_q} + (CW+1)'(i);
            if (s >= (CW+1)'(NUM_CH)) s = s - (CW+1)'(NUM_CH);
            j = s[CW-1:0];
            if (b_full[j] && b_prio[j] && !hit_hi) begin
                hit_hi = 1'b1;
                win_hi = j;
            end
            if (b_full[j] && !b_prio[j] && !hit_lo) begin
                hit_lo = 1'b1;
                win_lo = j;
            end
        end
        win = hit_hi ? win_hi : win_lo;
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        word_d    = word_q;
        fail_d    = fail_q;
        req_d     = req_q;
        rack_d    = rack_q;
        addr_d    = addr_q;
        data_d    = data_q;
        pend_d    = pend_q;
        prio_d    = prio_q;
        done_d    = '0;
        err_d     = '0;
        trunc_d   = '0;
        free_ch   = '0;
        close_msg = 1'b0;
`ifdef MBUS_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        unique case (state_q)
            ST_IDLE: if (|b_full) state_d = ST_ARB;
            ST_ARB: begin
                ch_d    = win;
                word_d  = '0;
                fail_d  = 1'b0;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                addr_d  = b_addr[ch_q];
                data_d  = b_data[ch_q];
                pend_d  = (word_q != b_last[ch_q]);
                prio_d  = b_prio[ch_q];
                req_d   = 1'b1;
                state_d = ST_ACKHI;
            end
            ST_ACKHI: if (ack_s || fail_s) begin
                req_d   = 1'b0;
                fail_d  = fail_s;
                state_d = ST_ACKLO;
            end
            ST_ACKLO: begin
                if (fail_s) fail_d = 1'b1;
                if (!ack_s) begin
                    if (fail_s || fail_q || !pend_q) begin
                        state_d = ST_RESP;
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_RESP: if (fail_q || fail_s || succ_s) begin
                rack_d  = 1'b1;
                fail_d  = fail_q || fail_s;
                state_d = ST_RESPCLR;
            end
            ST_RESPCLR: if (!succ_s && !fail_s) begin
                rack_d    = 1'b0;
                state_d   = ST_IDLE;
                close_msg = 1'b1;
`ifdef MBUS_TX_RETRY_EN
                if (fail_q && retry_q < RW'(MAX_RETRY)) begin
                    close_msg = 1'b0;
                    retry_d   = retry_q + 1'b1;
                    word_d    = '0;
                    fail_d    = 1'b0;
                    state_d   = ST_REQ;
                end else begin
                    retry_d = '0;
                end
`endif
                if (close_msg) begin
                    done_d[ch_q]  = 1'b1;
                    err_d[ch_q]   = fail_q;
                    trunc_d[ch_q] = b_trunc[ch_q];
                    free_ch[ch_q] = 1'b1;
                    rr_d = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            rr_q    <= '0;
            word_q  <= '0;
            fail_q  <= 1'b0;
            req_q   <= 1'b0;
            rack_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
            prio_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            trunc_q <= '0;
`ifdef MBUS_TX_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rr_q    <= rr_d;
            word_q  <= word_d;
            fail_q  <= fail_d;
            req_q   <= req_d;
            rack_q  <= rack_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            prio_q  <= prio_d;
            done_q  <= done_d;
            err_q   <= err_d;
            trunc_q <= trunc_d;
`ifdef MBUS_TX_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign tx.TX_ADDR     = addr_q;
    assign tx.TX_DATA     = data_q;
    assign tx.TX_PEND     = pend_q;
    assign tx.TX_REQ      = req_q;
    assign tx.PRIORITY    = prio_q;
    assign tx.TX_RESP_ACK = rack_q;
    assign CH_DONE        = done_q;
    assign CH_ERR         = err_q;
    assign CH_TRUNC       = trunc_q;
endmodule

// File: tb/tb_mbus_master_tx_sched.sv
// Scoreboard bench for mbus_master_tx_sched: client loader, node responder,
// completion monitor.
module tb_mbus_master_tx_sched;
    localparam int NCH = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;
`ifdef MBUS_TX_RETRY_EN
    localparam int NTX = 4;
`else
    localparam int NTX = 1;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          pend;
        logic          prio;
    } wexp_t;

    typedef struct packed {
        logic [NCH-1:0] done;
        logic [NCH-1:0] err;
        logic [NCH-1:0] trunc;
    } dexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH-1:0]    ch_valid, ch_ready, ch_last, ch_prio;
    logic [NCH-1:0]    ch_done, ch_err, ch_trunc;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_data;

    int    checks = 0;
    int    errors = 0;
    int    acc [NCH];
    wexp_t sb [$];
    dexp_t dq [$];

    mbus_master_tx_sched_if #(.ADDR_W(AW), .DATA_W(DW)) tx ();

    mbus_master_tx_sched #(
        .NUM_CH   (NCH),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (4),
        .MAX_RETRY(3)
    ) dut (
        .CLKIN   (clk),
        .RESETn  (rst_n),
        .CH_VALID(ch_valid),
        .CH_READY(ch_ready),
        .CH_LAST (ch_last),
        .CH_PRIO (ch_prio),
        .CH_ADDR (ch_addr),
        .CH_DATA (ch_data),
        .CH_DONE (ch_done),
        .CH_ERR  (ch_err),
        .CH_TRUNC(ch_trunc),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (|ch_done) dq.push_back({ch_done, ch_err, ch_trunc});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input int c, input int w);
        return DW'((c + 1) * 4096 + (w + 1) * 17);
    endfunction

    function automatic logic [AW-1:0] mkaddr(input int c);
        return AW'(8'hA0 + c * 3);
    endfunction

    task automatic expect_msg(input int c, input int n, input bit p, input int times);
        for (int t = 0; t < times; t++)
            for (int w = 0; w < n; w++)
                sb.push_back({mkaddr(c), mkdata(c, w), w != n - 1, p});
    endtask

    task automatic load(input logic [NCH-1:0] mask, input logic [NCH-1:0] pmask,
                        input int n, input bit use_last);
        logic [NCH-1:0] rdy;
        for (int c = 0; c < NCH; c++) acc[c] = 0;
        for (int w = 0; w < n; w++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (mask[c]) begin
                    ch_valid[c] = 1'b1;
                    ch_last[c]  = use_last && (w == n - 1);
                    ch_prio[c]  = pmask[c];
                    ch_data[c*DW +: DW] = mkdata(c, w);
                    ch_addr[c*AW +: AW] = mkaddr(c);
                end
            end
            rdy = ch_ready;
            @(posedge clk);
            for (int c = 0; c < NCH; c++)
                if (mask[c] && rdy[c]) acc[c]++;
        end
        @(negedge clk);
        ch_valid = '0;
        ch_last  = '0;
    endtask

    task automatic wait_req(input logic v);
        int n = 0;
        while (tx.TX_REQ !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (tx.TX_REQ !== v) chk("req_timeout", 64'(tx.TX_REQ), 64'(v));
    endtask

    task automatic wait_rack(input logic v);
        int n = 0;
        while (tx.TX_RESP_ACK !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (tx.TX_RESP_ACK !== v) chk("rack_timeout", 64'(tx.TX_RESP_ACK), 64'(v));
    endtask

    task automatic take_word(output bit more);
        wexp_t e;
        more = 1'b0;
        wait_req(1'b1);
        if (tx.TX_REQ !== 1'b1) return;
        if (sb.size() == 0) begin
            chk("sb_underrun", 64'(1), 64'(0));
            return;
        end
        e = sb.pop_front();
        chk("word", 64'({tx.TX_ADDR, tx.TX_DATA, tx.TX_PEND, tx.PRIORITY}), 64'(e));
        more = e.pend;
    endtask

    task automatic node_msg(input bit fail);
        bit more;
        more = 1'b1;
        while (more) begin
            take_word(more);
            if (tx.TX_REQ !== 1'b1) return;
            tx.TX_ACK = 1'b1;
            wait_req(1'b0);
            tx.TX_ACK = 1'b0;
        end
        @(negedge clk);
        if (fail) tx.TX_FAIL = 1'b1;
        else tx.TX_SUCC = 1'b1;
        wait_rack(1'b1);
        tx.TX_SUCC = 1'b0;
        tx.TX_FAIL = 1'b0;
        wait_rack(1'b0);
    endtask

    task automatic wait_done(input int c, input bit err, input bit tr);
        dexp_t d;
        int    n = 0;
        while (dq.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (dq.size() == 0) begin
            chk("done_timeout", 64'(0), 64'(1));
            return;
        end
        d = dq.pop_front();
        chk("done", 64'(d.done), 64'(1) << c);
        chk("err", 64'(d.err), 64'(err) << c);
        chk("trunc", 64'(d.trunc), 64'(tr) << c);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit more;
        ch_valid = '0;
        ch_last  = '0;
        ch_prio  = '0;
        ch_addr  = '0;
        ch_data  = '0;
        tx.TX_ACK  = 1'b0;
        tx.TX_SUCC = 1'b0;
        tx.TX_FAIL = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ch_ready), 64'(4'hF));
        chk("rst_ctl", 64'({tx.TX_REQ, tx.TX_RESP_ACK, tx.TX_PEND, tx.PRIORITY}), 64'(0));
        chk("rst_bus", 64'({tx.TX_ADDR, tx.TX_DATA}), 64'(0));
        chk("rst_done", 64'({ch_done, ch_err, ch_trunc}), 64'(0));
        rst_n = 1'b1;

        // single channel, 3 words, success
        expect_msg(0, 3, 1'b0, 1);
        load(4'b0001, 4'b0000, 3, 1'b1);
        chk("t1_busy", 64'(ch_ready[0]), 64'(0));
        node_msg(1'b0);
        wait_done(0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_ready", 64'(ch_ready[0]), 64'(1));

        // ch1 and ch2 together, same class
        expect_msg(1, 2, 1'b0, 1);
        expect_msg(2, 2, 1'b0, 1);
        load(4'b0110, 4'b0000, 2, 1'b1);
        node_msg(1'b0);
        wait_done(1, 1'b0, 1'b0);
        node_msg(1'b0);
        wait_done(2, 1'b0, 1'b0);

        // pointer now at 3: ch3 beats ch0 within the same class
        expect_msg(3, 2, 1'b0, 1);
        expect_msg(0, 2, 1'b0, 1);
        load(4'b1001, 4'b0000, 2, 1'b1);
        node_msg(1'b0);
        wait_done(3, 1'b0, 1'b0);
        node_msg(1'b0);
        wait_done(0, 1'b0, 1'b0);

        // pointer at 1: ch1 prio 0 would win on RR, ch3 prio 1 must win
        expect_msg(3, 2, 1'b1, 1);
        expect_msg(1, 2, 1'b0, 1);
        load(4'b1010, 4'b1000, 2, 1'b1);
        node_msg(1'b0);
        wait_done(3, 1'b0, 1'b0);
        node_msg(1'b0);
        wait_done(1, 1'b0, 1'b0);

        // persistent failure
        expect_msg(2, 2, 1'b0, NTX);
        load(4'b0100, 4'b0000, 2, 1'b1);
        for (int k = 0; k < NTX; k++) node_msg(1'b1);
        wait_done(2, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_quiet", 64'(tx.TX_REQ), 64'(0));
        chk("t5_no_extra_done", 64'(dq.size()), 64'(0));

        // five words without LAST into a 4-deep buffer
        expect_msg(0, 4, 1'b0, 1);
        load(4'b0001, 4'b0000, 5, 1'b0);
        chk("t6_accepted", 64'(acc[0]), 64'(4));
        chk("t6_ready_low", 64'(ch_ready[0]), 64'(0));
        node_msg(1'b0);
        wait_done(0, 1'b0, 1'b1);
        chk("t6_sb_empty", 64'(sb.size()), 64'(0));

        // reset while waiting for the ack of word 2
        expect_msg(1, 3, 1'b0, 1);
        load(4'b0110, 4'b0000, 3, 1'b1);
        take_word(more);
        tx.TX_ACK = 1'b1;
        wait_req(1'b0);
        tx.TX_ACK = 1'b0;
        take_word(more);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_req_low", 64'(tx.TX_REQ), 64'(0));
        chk("t7_rack_low", 64'(tx.TX_RESP_ACK), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t7_ready", 64'(ch_ready), 64'(4'hF));
        chk("t7_no_done", 64'(dq.size()), 64'(0));
        chk("t7_idle", 64'(tx.TX_REQ), 64'(0));
        sb.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
